ife_window_fetch: RTL

IFE_WINDOW_FETCH -- requirements
Module: ife_window_fetch

---
 rtl/ife_pkg.sv | 29 ++
 rtl/ife_line_buf.sv | 36 +++
 rtl/ife_window_fetch.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ife_pkg.sv
// Shared sizes, FSM encoding and window layout for the 3x3 window fetcher.
package ife_pkg;

    localparam int unsigned IMG_W   = 128;
    localparam int unsigned IMG_H   = 128;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned WIN_W   = 72;
    localparam int unsigned COORD_W = 7;
    localparam int unsigned CNT_W   = 15;
    localparam int unsigned WIN_DIM = 3;

    localparam int unsigned N_PIX        = IMG_W * IMG_H;
    // First window (0,0) completes when raster position (1,1) is shifted in.
    localparam int unsigned FILL_SHIFTS  = IMG_W + 1;
    // Real pixels plus the padded positions needed to close row 127.
    localparam int unsigned TOTAL_SHIFTS = N_PIX + FILL_SHIFTS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Window bytes indexed [dy][dx]; byte k = 3*dy+dx lands at bits [8k+7:8k].
    typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] win_t;

endpackage

// File: rtl/ife_line_buf.sv
// One image row of delay: 128x8 circular buffer with a shared read/write pointer.
module ife_line_buf
    import ife_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout_c
);

    logic [PIX_W-1:0]   mem [IMG_W];
    logic [COORD_W-1:0] ptr;

    // Pointer realigns to column 0 at every frame start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (shift_en) begin
            ptr <= ptr + COORD_W'(1);
        end
    end

    // Storage needs no reset; stale rows are always padded out.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[ptr] <= din;
        end
    end

    assign dout_c = mem[ptr];

endmodule

// File: rtl/ife_window_fetch.sv
// Raster 3x3 window fetcher for a 128x128 8-bit image with ready/valid output.
// Build option IFE_WIN_REPLICATE_PAD_EN: border positions replicate the nearest
// edge pixel instead of reading 0.
module ife_window_fetch
    import ife_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    output logic               busy,
    output logic [ADDR_W-1:0]  iaddr,
    input  logic [PIX_W-1:0]   idata,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [WIN_W-1:0]   win_data,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               win_last
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0]   FILL_CNT  = CNT_W'(FILL_SHIFTS);
    localparam logic [CNT_W-1:0]   END_CNT   = CNT_W'(TOTAL_SHIFTS);
    localparam logic [COORD_W-1:0] EDGE_MAX  = COORD_W'(IMG_W - 1);

    state_t             state, state_nxt;
    logic               pend;
    logic               skid_valid;
    logic [PIX_W-1:0]   skid_data;
    logic [CNT_W-1:0]   sh_cnt;
    win_t               sh_win;
    logic               sh_valid;
    logic [COORD_W-1:0] sh_row, sh_col;
    logic [COORD_W-1:0] ctr_row, ctr_col;
    logic [PIX_W-1:0]   lb0_q_c, lb1_q_c;

    logic               out_adv, shift_ok, src_avail, do_shift;
    logic               skid_load, skid_valid_nxt, issue, frame_clr;
    logic [PIX_W-1:0]   src_pix;

    logic               top_edge, bot_edge, left_edge, right_edge;
    logic [2:0]         row_out, col_out;
    logic [2:0][1:0]    row_src, col_src;
    win_t               pad_win;

    // Row buffers: lb0 holds the previous row, lb1 the one before it.
    ife_line_buf u_lb0 (
        .clk      (clk),
        .reset    (reset),
        .clr      (frame_clr),
        .shift_en (do_shift),
        .din      (src_pix),
        .dout_c   (lb0_q_c)
    );

    ife_line_buf u_lb1 (
        .clk      (clk),
        .reset    (reset),
        .clr      (frame_clr),
        .shift_en (do_shift),
        .din      (lb0_q_c),
        .dout_c   (lb1_q_c)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus pipeline flow control (output slot, shift stage, skid, fetch issue).
    always_comb begin
        state_nxt = state;
        frame_clr = (state == ST_IDLE) || (state == ST_DONE);
        out_adv   = !win_valid || win_ready;
        shift_ok  = !sh_valid || out_adv;
        src_avail = skid_valid || pend || (state == ST_FLUSH);
        src_pix   = skid_valid ? skid_data : (pend ? idata : '0);
        do_shift  = ((state == ST_FETCH) || (state == ST_FLUSH)) &&
                    src_avail && shift_ok && (sh_cnt < END_CNT);
        // Arriving pixel parks in the skid if the skid must drain first or the shift is blocked.
        skid_load = pend && (!do_shift || skid_valid);
        if (skid_load) begin
            skid_valid_nxt = 1'b1;
        end else if (do_shift && skid_valid) begin
            skid_valid_nxt = 1'b0;
        end else begin
            skid_valid_nxt = skid_valid;
        end
        // Only fetch when the skid will be free to absorb the returning pixel.
        issue = (state == ST_FETCH) && (iaddr != LAST_ADDR) && !skid_valid_nxt;

        unique case (state)
            ST_IDLE:  if (ready) state_nxt = ST_FETCH;
            ST_FETCH: if (pend && (iaddr == LAST_ADDR)) state_nxt = ST_FLUSH;
            ST_FLUSH: if (win_valid && win_ready && win_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Fetch side: address stepping, in-flight flag and skid register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= 1'b0;
            iaddr      <= '0;
            pend       <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            busy <= (state_nxt == ST_FETCH) || (state_nxt == ST_FLUSH);
            if (frame_clr) begin
                iaddr      <= '0;
                pend       <= (state == ST_IDLE) && ready;
                skid_valid <= 1'b0;
            end else begin
                pend       <= issue;
                skid_valid <= skid_valid_nxt;
                if (issue) begin
                    iaddr <= iaddr + ADDR_W'(1);
                end
                if (skid_load) begin
                    skid_data <= idata;
                end
            end
        end
    end

    // Shift stage: 3x3 register fed one column per step, tagged with its centre.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_cnt   <= '0;
            sh_win   <= '0;
            sh_valid <= 1'b0;
            sh_row   <= '0;
            sh_col   <= '0;
            ctr_row  <= '0;
            ctr_col  <= '0;
        end else if (frame_clr) begin
            sh_cnt   <= '0;
            sh_valid <= 1'b0;
            ctr_row  <= '0;
            ctr_col  <= '0;
        end else if (do_shift) begin
            sh_win[0] <= {lb1_q_c, sh_win[0][2:1]};
            sh_win[1] <= {lb0_q_c, sh_win[1][2:1]};
            sh_win[2] <= {src_pix, sh_win[2][2:1]};
            sh_cnt    <= sh_cnt + CNT_W'(1);
            if (sh_cnt >= FILL_CNT) begin
                sh_valid <= 1'b1;
                sh_row   <= ctr_row;
                sh_col   <= ctr_col;
                ctr_col  <= ctr_col + COORD_W'(1);
                if (ctr_col == EDGE_MAX) begin
                    ctr_row <= ctr_row + COORD_W'(1);
                end
            end else begin
                sh_valid <= 1'b0;
            end
        end else if (out_adv) begin
            sh_valid <= 1'b0;
        end
    end

    // Border handling: choose which stored row/column feeds each window byte.
    always_comb begin
        top_edge   = (sh_row == '0);
        bot_edge   = (sh_row == EDGE_MAX);
        left_edge  = (sh_col == '0);
        right_edge = (sh_col == EDGE_MAX);
`ifdef IFE_WIN_REPLICATE_PAD_EN
        row_out = '0;
        col_out = '0;
        row_src = {(bot_edge ? 2'd1 : 2'd2), 2'd1, (top_edge ? 2'd1 : 2'd0)};
        col_src = {(right_edge ? 2'd1 : 2'd2), 2'd1, (left_edge ? 2'd1 : 2'd0)};
`else
        row_out = {bot_edge, 1'b0, top_edge};
        col_out = {right_edge, 1'b0, left_edge};
        row_src = {2'd2, 2'd1, 2'd0};
        col_src = {2'd2, 2'd1, 2'd0};
`endif
        pad_win = '0;
        for (int unsigned dy = 0; dy < WIN_DIM; dy++) begin
            for (int unsigned dx = 0; dx < WIN_DIM; dx++) begin
                if (!(row_out[dy] || col_out[dx])) begin
                    pad_win[dy][dx] = sh_win[row_src[dy]][col_src[dx]];
                end
            end
        end
    end

    // Output slot: loads only when empty or being accepted, so fields hold during stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_valid <= 1'b0;
            win_data  <= '0;
            win_row   <= '0;
            win_col   <= '0;
            win_last  <= 1'b0;
        end else if (out_adv) begin
            win_valid <= sh_valid;
            if (sh_valid) begin
                win_data <= pad_win;
                win_row  <= sh_row;
                win_col  <= sh_col;
                win_last <= (sh_row == EDGE_MAX) && (sh_col == EDGE_MAX);
            end
        end
    end

endmodule
